// File: rtl/cache_controller.sv
// cache_controller: glue between the MEM stage, a 2-way two-word-line data
// cache and external memory. Read hits complete with zero wait cycles, read
// misses refill a whole 64-bit line, and stores are written through to memory.
// The cache line is updated only when the store hits.
module cache_controller #(
  parameter logic [31:0] BASE_ADDR = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_rd_en,
  input  logic        cpu_wr_en,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        ready,
  output logic        cache_en_read,
  output logic        cache_en_write,
  output logic        cache_update,
  output logic [18:0] cache_addr,
  output logic [31:0] cache_wdata0,
  output logic [31:0] cache_wdata1,
  input  logic        cache_hit,
  input  logic [31:0] cache_rdata,
  output logic        mem_rd_req,
  output logic        mem_wr_req,
  output logic [18:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    FILL    = 3'd2,
    WR_PEEK = 3'd3,
    WR_WAIT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] line_q, line_d;    // refill line captured from memory
  logic [31:0] other_q, other_d;  // sibling word read before a store hit
  logic        hit_q, hit_d;      // store hit status sampled in IDLE

  // Address relative to the cache window; wraps modulo 2^19 with no range check.
  logic [31:0] off_s;
  logic [18:0] a_s;
  logic        unused_s;

  assign off_s    = cpu_addr - BASE_ADDR;
  assign a_s      = off_s[18:0];
  assign unused_s = ^off_s[31:19];

  // State and datapath registers; async reset returns to IDLE with cleared data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      line_q  <= 64'd0;
      other_q <= 32'd0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      other_q <= other_d;
      hit_q   <= hit_d;
    end
  end

  // Next-state and output decode; every output is forced to 0 while rst is high.
  always_comb begin
    state_d        = state_q;
    line_d         = line_q;
    other_d        = other_q;
    hit_d          = hit_q;
    cpu_rdata      = 32'd0;
    ready          = 1'b0;
    cache_en_read  = 1'b0;
    cache_en_write = 1'b0;
    cache_update   = 1'b0;
    cache_addr     = 19'd0;
    cache_wdata0   = 32'd0;
    cache_wdata1   = 32'd0;
    mem_rd_req     = 1'b0;
    mem_wr_req     = 1'b0;
    mem_addr       = 19'd0;
    mem_wdata      = 32'd0;

    if (rst) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          cache_addr = a_s;
          if (cpu_wr_en) begin
            // Stores take priority; remember whether the line is cached.
            hit_d   = cache_hit;
            state_d = WR_PEEK;
          end else if (cpu_rd_en) begin
            if (cache_hit) begin
              cache_en_read = 1'b1;
              cpu_rdata     = cache_rdata;
              ready         = 1'b1;
            end else begin
              state_d = RD_WAIT;
            end
          end else begin
            state_d = IDLE;
          end
        end

        RD_WAIT: begin
          mem_rd_req = 1'b1;
          mem_addr   = {a_s[18:3], 3'b000};
          if (mem_ready) begin
            line_d  = mem_rdata;
            state_d = FILL;
          end else begin
            state_d = RD_WAIT;
          end
        end

        FILL: begin
          // Allocate the refilled line into the LRU way and return the word.
          cache_en_write = 1'b1;
          cache_update   = 1'b0;
          cache_addr     = a_s;
          cache_wdata0   = line_q[31:0];
          cache_wdata1   = line_q[63:32];
          cpu_rdata      = a_s[2] ? line_q[63:32] : line_q[31:0];
          ready          = 1'b1;
          state_d        = IDLE;
        end

        WR_PEEK: begin
          // Read the other word of the line so a hit can rewrite it intact.
          cache_addr = {a_s[18:3], ~a_s[2], a_s[1:0]};
          other_d    = cache_rdata;
          state_d    = WR_WAIT;
        end

        WR_WAIT: begin
          mem_wr_req = 1'b1;
          mem_addr   = {a_s[18:2], 2'b00};
          mem_wdata  = cpu_wdata;
          cache_addr = a_s;
          if (mem_ready) begin
            ready   = 1'b1;
            state_d = IDLE;
            if (hit_q) begin
              cache_en_write = 1'b1;
              cache_update   = 1'b1;
              cache_wdata0   = a_s[2] ? other_q : cpu_wdata;
              cache_wdata1   = a_s[2] ? cpu_wdata : other_q;
            end else begin
              cache_en_write = 1'b0;
            end
          end else begin
            state_d = WR_WAIT;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule
